// File: rtl/bip_ctrl_if.sv
// Program-memory and datapath bus of the accumulator-CPU control unit.
// master = control unit, slave = program ROM plus accumulator datapath.
interface bip_ctrl_if #(
  parameter int PC_W  = 11,
  parameter int OPR_W = 11,
  parameter int OPC_W = 5
);
  logic                   en;
  logic [OPC_W+OPR_W-1:0] instr;
  logic                   acc_zero;
  logic                   acc_neg;
  logic [PC_W-1:0]        pc_addr;
  logic [OPR_W-1:0]       operand;
  logic [1:0]             sel_a;
  logic                   sel_b;
  logic                   op;
  logic                   wr_acc;
  logic                   wr_ram;
  logic                   rd_ram;

  modport master (
    input  en, instr, acc_zero, acc_neg,
    output pc_addr, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram
  );

  modport slave (
    output en, instr, acc_zero, acc_neg,
    input  pc_addr, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram
  );
endinterface

// File: rtl/bip_ctrl_unit.sv
// Sequential control unit of the accumulator CPU: owns the PC, runs FETCH/EXEC/HALT,
// decodes the instruction in EXEC and drives the datapath strobes for that one cycle.
module bip_ctrl_unit #(
  parameter int PC_W  = 11,
  parameter int OPR_W = 11,
  parameter int OPC_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  bip_ctrl_if.master       bus,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  if (OPC_W < 4) begin : g_opc_w_check
    $error("bip_ctrl_unit: OPC_W must be at least 4");
  end

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(11);

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [OPC_W-1:0] opcode;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  target;

  logic [1:0]      d_sel_a;
  logic            d_sel_b, d_op, d_wr_acc, d_wr_ram, d_rd_ram;
  logic [PC_W-1:0] pc_next;
  logic            to_halt, bad_opc;
  logic            active;

  assign opcode      = bus.instr[OPC_W+OPR_W-1 -: OPC_W];
  assign bus.operand = bus.instr[OPR_W-1:0];
  assign bus.pc_addr = pc;
  assign pc_inc      = pc + PC_W'(1);
  // Truncates a wide operand or zero-extends a narrow one.
  assign target      = PC_W'(bus.operand);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    d_sel_a  = 2'd0;
    d_sel_b  = 1'b0;
    d_op     = 1'b0;
    d_wr_acc = 1'b0;
    d_wr_ram = 1'b0;
    d_rd_ram = 1'b0;
    pc_next  = pc_inc;
    to_halt  = 1'b0;
    bad_opc  = 1'b0;
    case (opcode)
      OP_HLT:  begin pc_next = pc; to_halt = 1'b1; end
      OP_STO:  d_wr_ram = 1'b1;
      OP_LD:   begin d_wr_acc = 1'b1; d_rd_ram = 1'b1; end
      OP_LDI:  begin d_sel_a = 2'd1; d_wr_acc = 1'b1; end
      OP_ADD:  begin d_sel_a = 2'd2; d_op = 1'b1; d_wr_acc = 1'b1; d_rd_ram = 1'b1; end
      OP_ADDI: begin d_sel_a = 2'd2; d_sel_b = 1'b1; d_op = 1'b1; d_wr_acc = 1'b1; end
      OP_SUB:  begin d_sel_a = 2'd2; d_wr_acc = 1'b1; d_rd_ram = 1'b1; end
      OP_SUBI: begin d_sel_a = 2'd2; d_sel_b = 1'b1; d_wr_acc = 1'b1; end
      OP_BEQ:  if (bus.acc_zero)  pc_next = target;
      OP_BNE:  if (!bus.acc_zero) pc_next = target;
      OP_BLT:  if (bus.acc_neg)   pc_next = target;
      OP_JMP:  pc_next = target;
      default: begin pc_next = pc; to_halt = 1'b1; bad_opc = 1'b1; end
    endcase
  end

  // Reset masks the strobes combinationally so a reset landing in EXEC never writes.
  assign active     = (state == S_EXEC) && !rst;
  assign bus.sel_a  = active ? d_sel_a  : 2'd0;
  assign bus.sel_b  = active ? d_sel_b  : 1'b0;
  assign bus.op     = active ? d_op     : 1'b0;
  assign bus.wr_acc = active ? d_wr_acc : 1'b0;
  assign bus.wr_ram = active ? d_wr_ram : 1'b0;
  assign bus.rd_ram = active ? d_rd_ram : 1'b0;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      instr_cnt <= '0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (bus.en) state <= S_EXEC;
        S_EXEC: begin
          pc <= pc_next;
          if (to_halt) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= illegal | bad_opc;
          end else begin
            state <= S_FETCH;
            if (instr_cnt != {CNT_W{1'b1}}) instr_cnt <= instr_cnt + CNT_W'(1);
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_ctrl_unit.sv
// Directed bench for bip_ctrl_unit: a default-size unit for decode, branch, halt and
// reset cases, and a PC_W=4 / CNT_W=3 unit for PC wrap and counter saturation.
module tb_bip_ctrl_unit;

  localparam logic [4:0] HLT = 5'd0,  STO = 5'd1,  LD  = 5'd2,  LDI  = 5'd3;
  localparam logic [4:0] ADD = 5'd4,  ADDI = 5'd5, SUB = 5'd6,  SUBI = 5'd7;
  localparam logic [4:0] BEQ = 5'd8,  BNE = 5'd9,  BLT = 5'd10, JMP  = 5'd11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bip_ctrl_if              bus ();
  bip_ctrl_if #(.PC_W(4))  bus2 ();

  logic        halted, illegal, halted2, illegal2;
  logic [15:0] cnt;
  logic [2:0]  cnt2;

  logic [15:0] rom  [0:2047];
  logic [15:0] rom2 [0:15];
  assign bus.instr  = rom[bus.pc_addr];
  assign bus2.instr = rom2[bus2.pc_addr];

  bip_ctrl_unit dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .halted(halted), .illegal(illegal), .instr_cnt(cnt)
  );

  bip_ctrl_unit #(.PC_W(4), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master),
    .halted(halted2), .illegal(illegal2), .instr_cnt(cnt2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] opc, input logic [10:0] opr);
    return {opc, opr};
  endfunction

  // {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram}
  function automatic logic [6:0] strb();
    return {bus.sel_a, bus.sel_b, bus.op, bus.wr_acc, bus.wr_ram, bus.rd_ram};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
  endtask

  task automatic run_branch(input string tag, input logic [4:0] opc, input logic az,
                            input logic an, input logic [10:0] exp_pc);
    rom[0] = mk(opc, 11'h040);
    rom[1] = mk(HLT, 11'h000);
    bus.acc_zero = az;
    bus.acc_neg  = an;
    bus.en       = 1'b1;
    do_reset();
    tick(1);
    check({tag, "_strobes"}, 32'(strb()), 32'd0);
    tick(1);
    check({tag, "_pc"}, 32'(bus.pc_addr), 32'(exp_pc));
    check({tag, "_cnt"}, 32'(cnt), 32'd1);
  endtask

  logic [6:0]  exp_vec [0:11];
  logic [4:0]  opc;
  logic [10:0] opr;

  initial begin
    bus.en = 1'b0; bus.acc_zero = 1'b0; bus.acc_neg = 1'b0;
    bus2.en = 1'b0; bus2.acc_zero = 1'b0; bus2.acc_neg = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 16; i++) rom2[i] = mk(ADDI, 11'd1);

    exp_vec[0]  = 7'b00_0_0_0_0_0;  // HLT
    exp_vec[1]  = 7'b00_0_0_0_1_0;  // STO
    exp_vec[2]  = 7'b00_0_0_1_0_1;  // LD
    exp_vec[3]  = 7'b01_0_0_1_0_0;  // LDI
    exp_vec[4]  = 7'b10_0_1_1_0_1;  // ADD
    exp_vec[5]  = 7'b10_1_1_1_0_0;  // ADDI
    exp_vec[6]  = 7'b10_0_0_1_0_1;  // SUB
    exp_vec[7]  = 7'b10_1_0_1_0_0;  // SUBI
    for (int i = 8; i < 12; i++) exp_vec[i] = 7'd0;

    // Small program: LDI 5; ADDI 3; STO 7; HLT
    rom[0] = mk(LDI, 11'd5);
    rom[1] = mk(ADDI, 11'd3);
    rom[2] = mk(STO, 11'd7);
    rom[3] = mk(HLT, 11'd0);
    bus.en = 1'b1;
    do_reset();
    check("rst_pc", 32'(bus.pc_addr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_strobes", 32'(strb()), 32'd0);
    tick(1);
    check("prog_ldi_strobes", 32'(strb()), 32'(exp_vec[3]));
    check("prog_ldi_operand", 32'(bus.operand), 32'd5);
    tick(4);
    check("prog_sto_wr_ram", 32'(bus.wr_ram), 32'd1);
    check("prog_sto_operand", 32'(bus.operand), 32'd7);
    tick(3);
    check("prog_halted", 32'(halted), 32'd1);
    check("prog_cnt", 32'(cnt), 32'd3);
    check("prog_pc", 32'(bus.pc_addr), 32'd3);
    tick(5);
    check("prog_still_halted", 32'(halted), 32'd1);
    check("prog_pc_held", 32'(bus.pc_addr), 32'd3);
    check("prog_halt_strobes", 32'(strb()), 32'd0);

    // Decode sweep: opcodes 1..11 at addresses 0..10, HLT at 11; branches fall through.
    for (int i = 0; i < 12; i++) begin
      opc = (i < 11) ? 5'(i + 1) : HLT;
      opr = 11'h0A0 + 11'(i);
      if (opc == BEQ || opc == BNE || opc == BLT) opr = 11'h040;
      if (opc == JMP) opr = 11'd11;
      rom[i] = mk(opc, opr);
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      opc = (i < 11) ? 5'(i + 1) : HLT;
      check($sformatf("sweep_fetch_pc_%0d", i), 32'(bus.pc_addr), 32'(i));
      check($sformatf("sweep_fetch_strobes_%0d", i), 32'(strb()), 32'd0);
      bus.acc_zero = (opc != BEQ);
      bus.acc_neg  = (opc != BLT);
      tick(1);
      check($sformatf("sweep_exec_strobes_op%0d", opc), 32'(strb()), 32'(exp_vec[opc]));
      tick(1);
    end
    check("sweep_halted", 32'(halted), 32'd1);
    check("sweep_pc", 32'(bus.pc_addr), 32'd11);
    check("sweep_cnt", 32'(cnt), 32'd11);

    // Branches to 0x040, taken and not taken.
    run_branch("beq_taken",    BEQ, 1'b1, 1'b0, 11'h040);
    run_branch("beq_fall",     BEQ, 1'b0, 1'b1, 11'h001);
    run_branch("bne_taken",    BNE, 1'b0, 1'b0, 11'h040);
    run_branch("bne_fall",     BNE, 1'b1, 1'b1, 11'h001);
    run_branch("blt_taken",    BLT, 1'b0, 1'b1, 11'h040);
    run_branch("blt_fall",     BLT, 1'b1, 1'b0, 11'h001);
    run_branch("jmp_taken",    JMP, 1'b0, 1'b0, 11'h040);

    // Illegal opcode 0x1F at address 1.
    rom[0] = mk(LDI, 11'd1);
    rom[1] = mk(5'h1F, 11'h000);
    do_reset();
    tick(3);
    check("ill_exec_strobes", 32'(strb()), 32'd0);
    tick(1);
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_pc", 32'(bus.pc_addr), 32'd1);
    check("ill_cnt", 32'(cnt), 32'd1);
    tick(10);
    check("ill_sticky_illegal", 32'(illegal), 32'd1);
    check("ill_sticky_halted", 32'(halted), 32'd1);
    check("ill_sticky_pc", 32'(bus.pc_addr), 32'd1);
    do_reset();
    check("ill_rst_illegal", 32'(illegal), 32'd0);
    check("ill_rst_halted", 32'(halted), 32'd0);
    check("ill_rst_pc", 32'(bus.pc_addr), 32'd0);

    // en=0 in FETCH, then reset during an STO EXEC, then en dropped mid-EXEC.
    rom[0] = mk(STO, 11'd7);
    rom[1] = mk(HLT, 11'd0);
    bus.en = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("en0_pc_%0d", i), 32'(bus.pc_addr), 32'd0);
      check($sformatf("en0_strobes_%0d", i), 32'(strb()), 32'd0);
    end
    bus.en = 1'b1;
    tick(1);
    check("sto_wr_ram", 32'(bus.wr_ram), 32'd1);
    rst = 1'b1;
    #1;
    check("sto_rst_wr_ram", 32'(bus.wr_ram), 32'd0);
    tick(1);
    rst = 1'b0;
    #1;
    check("sto_rst_pc", 32'(bus.pc_addr), 32'd0);
    check("sto_rst_strobes", 32'(strb()), 32'd0);
    tick(1);
    check("sto_refetch_wr_ram", 32'(bus.wr_ram), 32'd1);
    bus.en = 1'b0;
    tick(1);
    check("en_drop_pc", 32'(bus.pc_addr), 32'd1);
    check("en_drop_cnt", 32'(cnt), 32'd1);

    // Reset wins over HLT in the same cycle.
    rom[0] = mk(HLT, 11'd0);
    bus.en = 1'b1;
    do_reset();
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    check("rst_hlt_halted", 32'(halted), 32'd0);
    check("rst_hlt_pc", 32'(bus.pc_addr), 32'd0);
    tick(2);
    check("rst_hlt_later_halted", 32'(halted), 32'd1);

    // PC_W=4 wrap and CNT_W=3 saturation on the small unit.
    bus.en  = 1'b0;
    bus2.en = 1'b1;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wrap_pc_%0d", k), 32'(bus2.pc_addr), 32'(k));
      check($sformatf("sat_cnt_%0d", k), 32'(cnt2), 32'((k < 7) ? k : 7));
      tick(2);
    end
    check("wrap_pc_back_to_0", 32'(bus2.pc_addr), 32'd0);
    check("sat_cnt_final", 32'(cnt2), 32'd7);
    check("wrap_no_halt", 32'(halted2), 32'd0);
    check("wrap_no_illegal", 32'(illegal2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
